hs32_aic: RTL and testbench

//  Advanced interrupt controller: sits directly upstream of hs32_cpu. Latches rising edges on the
//  CPU/peripheral interrupt lines, holds a programmable per-line handler table, arbitrates pending

---
 rtl/hs32_aic_pkg.sv | 22 ++
 rtl/hs32_aic_prio.sv | 45 ++++
 rtl/hs32_aic.sv | 194 +++++++++++++++++++
 tb/tb_hs32_aic.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hs32_aic_pkg.sv
// Shared definitions for the hs32 advanced interrupt controller: entry field positions,
// pending-register index, FSM encodings and the handler-address helper.
package hs32_aic_pkg;

    localparam int AIC_EN      = 0;
    localparam int AIC_NMI     = 1;
    localparam int AIC_ADDR_HI = 31;
    localparam int AIC_ADDR_LO = 2;

    localparam logic [4:0] AIC_PEND_IDX = 5'd31;

    typedef enum logic [1:0] {
        AIC_IDLE = 2'b00,
        AIC_REQ  = 2'b01,
        AIC_GAP  = 2'b10
    } aic_state_e;

    function automatic logic [31:0] aic_handler(input logic [31:0] entry);
        return {entry[AIC_ADDR_HI:AIC_ADDR_LO], 2'b00};
    endfunction

endpackage

// File: rtl/hs32_aic_prio.sv
// Two-class priority encoder: NMI-flagged pending lines beat the rest; within the chosen
// class the search starts at 'base' and wraps (base = 0 gives fixed lowest-index priority).
module hs32_aic_prio #(
    parameter int NUM_INT = 24
) (
    input  logic [NUM_INT-1:0] pend,
    input  logic [NUM_INT-1:0] nmi_mask,
    input  logic [4:0]         base,
    output logic               valid,
    output logic [4:0]         idx
);

    logic [NUM_INT-1:0] nmi_s;
    logic [NUM_INT-1:0] cls_s;
    logic               found_s;

    // Class selection followed by a rotated first-one search
    always_comb begin
        nmi_s   = pend & nmi_mask;
        found_s = 1'b0;
        idx     = 5'd0;
        if (|nmi_s) begin
            cls_s = nmi_s;
        end else begin
            cls_s = pend & ~nmi_mask;
        end
        for (int k = 0; k < NUM_INT; k++) begin
            int j;
            j = int'(base) + k;
            if (j >= NUM_INT) begin
                j = j - NUM_INT;
            end else begin
                j = j;
            end
            if (!found_s && cls_s[j]) begin
                found_s = 1'b1;
                idx     = 5'(j);
            end else begin
                found_s = found_s;
            end
        end
        valid = found_s;
    end

endmodule

// File: rtl/hs32_aic.sv
// hs32 advanced interrupt controller: handler table, edge-latched pending lines, request FSM.
// Optional macro AIC_ROUND_ROBIN_EN rotates the in-class search start past the last served vector.
module hs32_aic
    import hs32_aic_pkg::*;
#(
    parameter int NUM_INT = 24
) (
    input  logic               i_clk,
    input  logic               reset,
    input  logic               stb,
    output logic               ack,
    input  logic               rw,
    input  logic [4:0]         addr,
    input  logic [31:0]        dwrite,
    output logic [31:0]        dread,
    input  logic [NUM_INT-1:0] interrupts,
    input  logic               iack,
    output logic [31:0]        handler,
    output logic               intrq,
    output logic [4:0]         vec,
    output logic               nmi
);

    localparam logic [5:0] NUM_INT_W = 6'(NUM_INT);

    logic [31:0]        table_q [NUM_INT];
    logic [31:0]        table_d [NUM_INT];
    logic [NUM_INT-1:0] pend_q, pend_d, prev_q;
    logic [NUM_INT-1:0] set_s, nmi_mask_s, w1c_s, dis_clr_s, iack_clr_s;
    logic               ack_q, ack_d, intrq_q, intrq_d, nmi_q, nmi_d;
    logic [31:0]        dread_q, dread_d, handler_q, handler_d;
    logic [4:0]         vec_q, vec_d, base_s, win_idx_s;
    logic               win_valid_s, accept_s, in_table_s;
    aic_state_e         state_q, state_d;

    // Per-line rising-edge qualification and NMI class mask
    always_comb begin
        for (int i = 0; i < NUM_INT; i++) begin
            set_s[i]      = interrupts[i] & ~prev_q[i] & table_q[i][AIC_EN];
            nmi_mask_s[i] = table_q[i][AIC_NMI];
        end
    end

`ifdef AIC_ROUND_ROBIN_EN
    logic [4:0] last_q, last_d;

    // Rotated search base: one past the last served vector, wrapping at NUM_INT
    always_comb begin
        if ({1'b0, last_q} == (NUM_INT_W - 6'd1)) begin
            base_s = 5'd0;
        end else begin
            base_s = last_q + 5'd1;
        end
        if (state_q == AIC_REQ && iack) begin
            last_d = vec_q;
        end else begin
            last_d = last_q;
        end
    end

    // Last-served vector register
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            last_q <= 5'(NUM_INT - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign base_s = 5'd0;
`endif

    hs32_aic_prio #(.NUM_INT(NUM_INT)) u_prio (
        .pend     (pend_q),
        .nmi_mask (nmi_mask_s),
        .base     (base_s),
        .valid    (win_valid_s),
        .idx      (win_idx_s)
    );

    // Config bus: table writes, W1C on the pending word, registered read data and ack
    always_comb begin
        accept_s   = stb & ~ack_q;
        in_table_s = ({1'b0, addr} < NUM_INT_W);
        table_d    = table_q;
        w1c_s      = '0;
        dis_clr_s  = '0;
        ack_d      = accept_s;
        dread_d    = dread_q;
        if (accept_s && rw) begin
            dread_d = 32'd0;
            if (in_table_s) begin
                table_d[addr]   = dwrite;
                dis_clr_s[addr] = ~dwrite[AIC_EN];
            end else if (addr == AIC_PEND_IDX) begin
                w1c_s = dwrite[NUM_INT-1:0];
            end else begin
                w1c_s = '0;
            end
        end else if (accept_s) begin
            if (in_table_s) begin
                dread_d = table_q[addr];
            end else if (addr == AIC_PEND_IDX) begin
                dread_d = 32'(pend_q);
            end else begin
                dread_d = 32'd0;
            end
        end else begin
            dread_d = dread_q;
        end
    end

    // Request FSM; outputs are captured on entry to REQ and held until iack
    always_comb begin
        state_d    = state_q;
        intrq_d    = intrq_q;
        vec_d      = vec_q;
        handler_d  = handler_q;
        nmi_d      = nmi_q;
        iack_clr_s = '0;
        case (state_q)
            AIC_IDLE: begin
                if (win_valid_s) begin
                    state_d   = AIC_REQ;
                    intrq_d   = 1'b1;
                    vec_d     = win_idx_s;
                    handler_d = aic_handler(table_q[win_idx_s]);
                    nmi_d     = table_q[win_idx_s][AIC_NMI];
                end else begin
                    intrq_d = 1'b0;
                end
            end
            AIC_REQ: begin
                if (iack) begin
                    iack_clr_s[vec_q] = 1'b1;
                    intrq_d           = 1'b0;
                    state_d           = AIC_GAP;
                end else begin
                    intrq_d = 1'b1;
                end
            end
            AIC_GAP: begin
                intrq_d = 1'b0;
                state_d = AIC_IDLE;
            end
            default: begin
                intrq_d = 1'b0;
                state_d = AIC_IDLE;
            end
        endcase
    end

    // New edges win over iack/W1C clears; disabling a line always drops its pending bit
    always_comb begin
        pend_d = ((pend_q & ~(w1c_s | iack_clr_s)) | set_s) & ~dis_clr_s;
    end

    // State, table and output registers
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_INT; i++) begin
                table_q[i] <= 32'd0;
            end
            pend_q    <= '0;
            prev_q    <= '0;
            ack_q     <= 1'b0;
            dread_q   <= 32'd0;
            intrq_q   <= 1'b0;
            vec_q     <= 5'd0;
            handler_q <= 32'd0;
            nmi_q     <= 1'b0;
            state_q   <= AIC_IDLE;
        end else begin
            table_q   <= table_d;
            pend_q    <= pend_d;
            prev_q    <= interrupts;
            ack_q     <= ack_d;
            dread_q   <= dread_d;
            intrq_q   <= intrq_d;
            vec_q     <= vec_d;
            handler_q <= handler_d;
            nmi_q     <= nmi_d;
            state_q   <= state_d;
        end
    end

    assign ack     = ack_q;
    assign dread   = dread_q;
    assign intrq   = intrq_q;
    assign vec     = vec_q;
    assign handler = handler_q;
    assign nmi     = nmi_q;

endmodule

// File: tb/tb_hs32_aic.sv
// Self-checking bench for hs32_aic: table-driven register vectors plus directed request sequences.
module tb_hs32_aic;

    localparam int NUM_INT = 24;

    logic               i_clk = 1'b0;
    logic               reset;
    logic               stb, ack, rw, iack, intrq, nmi;
    logic [4:0]         addr, vec;
    logic [31:0]        dwrite, dread, handler, rd;
    logic [NUM_INT-1:0] interrupts;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [4:0]  a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp;
    } bus_vec_t;

    bus_vec_t vecs [10];
    logic [4:0] rr_exp [4];

    hs32_aic #(.NUM_INT(NUM_INT)) dut (
        .i_clk      (i_clk),
        .reset      (reset),
        .stb        (stb),
        .ack        (ack),
        .rw         (rw),
        .addr       (addr),
        .dwrite     (dwrite),
        .dread      (dread),
        .interrupts (interrupts),
        .iack       (iack),
        .handler    (handler),
        .intrq      (intrq),
        .vec        (vec),
        .nmi        (nmi)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d, output logic [31:0] r);
        int n;
        stb = 1'b1; rw = w; addr = a; dwrite = d; n = 0;
        do begin
            tick();
            n++;
        end while (!ack && n < 8);
        check("bus_ack", {31'd0, ack}, 32'd1);
        r = dread;
        stb = 1'b0; rw = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic [NUM_INT-1:0] m);
        interrupts = m;
        tick();
        interrupts = '0;
    endtask

    task automatic wait_intrq();
        int n;
        n = 0;
        while (!intrq && n < 10) begin
            tick();
            n++;
        end
        check("wait_intrq", {31'd0, intrq}, 32'd1);
    endtask

    task automatic retire();
        iack = 1'b1;
        tick();
        iack = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'd5,  32'd0,          1'b1, 32'd0};
        vecs[1] = '{1'b1, 5'd3,  32'h0000_1001,  1'b0, 32'd0};
        vecs[2] = '{1'b0, 5'd3,  32'd0,          1'b1, 32'h0000_1001};
        vecs[3] = '{1'b1, 5'd10, 32'hCAFE_0000,  1'b0, 32'd0};
        vecs[4] = '{1'b0, 5'd10, 32'd0,          1'b1, 32'hCAFE_0000};
        vecs[5] = '{1'b1, 5'd24, 32'hFFFF_FFFF,  1'b0, 32'd0};
        vecs[6] = '{1'b0, 5'd24, 32'd0,          1'b1, 32'd0};
        vecs[7] = '{1'b0, 5'd30, 32'd0,          1'b1, 32'd0};
        vecs[8] = '{1'b0, 5'd31, 32'd0,          1'b1, 32'd0};
        vecs[9] = '{1'b1, 5'd23, 32'h1234_5678,  1'b0, 32'd0};
`ifdef AIC_ROUND_ROBIN_EN
        rr_exp = '{5'd1, 5'd4, 5'd1, 5'd4};
`else
        rr_exp = '{5'd1, 5'd1, 5'd1, 5'd1};
`endif

        reset = 1'b0; stb = 1'b0; rw = 1'b0; addr = 5'd0; dwrite = 32'd0;
        interrupts = '0; iack = 1'b0;
        tick(); tick();
        check("rst_intrq", {31'd0, intrq}, 32'd0);
        check("rst_handler", handler, 32'd0);
        reset = 1'b1;
        tick();

        // Register access vectors
        for (int i = 0; i < 10; i++) begin
            bus(vecs[i].wr, vecs[i].a, vecs[i].d, rd);
            if (vecs[i].chk) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
        end
        bus(1'b0, 5'd23, 32'd0, rd);
        check("rd_e23", rd, 32'h1234_5678);

        // Single request: latency, outputs, iack retire
        pulse(24'h000008);
        check("t2_n1_intrq", {31'd0, intrq}, 32'd0);
        tick();
        check("t2_intrq", {31'd0, intrq}, 32'd1);
        check("t2_vec", {27'd0, vec}, 32'd3);
        check("t2_handler", handler, 32'h0000_1000);
        check("t2_nmi", {31'd0, nmi}, 32'd0);
        retire();
        check("t2_iack_intrq", {31'd0, intrq}, 32'd0);
        bus(1'b0, 5'd31, 32'd0, rd);
        check("t2_pend", rd, 32'd0);

        // NMI beats lower index, then the other line after GAP
        bus(1'b1, 5'd2, 32'h0000_2001, rd);
        bus(1'b1, 5'd7, 32'h0000_7003, rd);
        pulse(24'h000084);
        tick();
        check("t3_vec_a", {27'd0, vec}, 32'd7);
        check("t3_nmi_a", {31'd0, nmi}, 32'd1);
        check("t3_handler_a", handler, 32'h0000_7000);
        retire();
        check("t3_gap_intrq", {31'd0, intrq}, 32'd0);
        tick();
        check("t3_idle_intrq", {31'd0, intrq}, 32'd0);
        tick();
        check("t3_intrq_b", {31'd0, intrq}, 32'd1);
        check("t3_vec_b", {27'd0, vec}, 32'd2);
        check("t3_nmi_b", {31'd0, nmi}, 32'd0);
        check("t3_handler_b", handler, 32'h0000_2000);
        retire();
        tick(); tick();

        // Disabled line never pends; W1C clears a pending line before it is served
        bus(1'b1, 5'd9, 32'h0000_9000, rd);
        pulse(24'h000200);
        tick(); tick();
        check("t4_dis_intrq", {31'd0, intrq}, 32'd0);
        bus(1'b0, 5'd31, 32'd0, rd);
        check("t4_dis_pend", rd, 32'd0);
        pulse(24'h000080);
        tick();
        check("t4_vec7", {27'd0, vec}, 32'd7);
        pulse(24'h000008);
        bus(1'b0, 5'd31, 32'd0, rd);
        check("t4_pend_pre", rd, 32'h0000_0088);
        bus(1'b1, 5'd31, 32'h0000_0008, rd);
        bus(1'b0, 5'd31, 32'd0, rd);
        check("t4_pend_w1c", rd, 32'h0000_0080);
        check("t4_hold_vec", {27'd0, vec}, 32'd7);
        retire();
        tick(); tick(); tick();
        check("t4_no_req", {31'd0, intrq}, 32'd0);
        bus(1'b0, 5'd31, 32'd0, rd);
        check("t4_pend_end", rd, 32'd0);

        // Edge in the iack cycle survives the clear
        pulse(24'h000008);
        tick();
        check("t5_vec_a", {27'd0, vec}, 32'd3);
        iack = 1'b1; interrupts = 24'h000008;
        tick();
        iack = 1'b0; interrupts = '0;
        check("t5_gap", {31'd0, intrq}, 32'd0);
        tick();
        check("t5_idle", {31'd0, intrq}, 32'd0);
        tick();
        check("t5_intrq_b", {31'd0, intrq}, 32'd1);
        check("t5_vec_b", {27'd0, vec}, 32'd3);
        retire();
        tick(); tick();
        bus(1'b0, 5'd31, 32'd0, rd);
        check("t5_pend_end", rd, 32'd0);

        // Arbitration order across repeated requests on lines 1 and 4
        bus(1'b1, 5'd1, 32'h0000_0101, rd);
        bus(1'b1, 5'd4, 32'h0000_0401, rd);
        for (int k = 0; k < 4; k++) begin
            pulse(24'h000012);
            wait_intrq();
            check($sformatf("t6_vec%0d", k), {27'd0, vec}, {27'd0, rr_exp[k]});
            retire();
        end

        // Asynchronous reset in the middle of a request
        wait_intrq();
        reset = 1'b0;
        #1;
        check("t1_mid_intrq", {31'd0, intrq}, 32'd0);
        check("t1_mid_vec", {27'd0, vec}, 32'd0);
        check("t1_mid_handler", handler, 32'd0);
        #5;
        reset = 1'b1;
        tick();
        bus(1'b0, 5'd3, 32'd0, rd);
        check("t1_tbl3", rd, 32'd0);
        bus(1'b0, 5'd31, 32'd0, rd);
        check("t1_pend", rd, 32'd0);
        check("t1_post_intrq", {31'd0, intrq}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
